ahb_sram_slave: RTL and testbench
=================================

// Module: ahb_sram_slave
// PURPOSE
//  AHB-Lite slave that terminates bus transfers onto a single-port synchronous SRAM
//  (1-cycle read latency). It decodes HTRANS/HSIZE, generates byte strobes and returns
//  HREADYOUT/HRESP coded with the shared AHB enum types.
//  It sits directly downstream of the AHB interconnect, one instance per memory region.
// PARAMETERS
//  ADDR_WIDTH  32    HADDR width
//  MEM_DEPTH   1024  SRAM depth in 32-bit words; the data bus is fixed at 32 bits
// PORTS
//  clk_i            in   1           clock
//  rst_n_i          in   1           reset, synchronous, active-low
//  ahb_hsel_i       in   1           slave select
//  ahb_haddr_i      in   ADDR_WIDTH  byte address
//  ahb_htrans_i     in   2           ahb_trans_t
//  ahb_hsize_i      in   3           ahb_size_t
//  ahb_hburst_i     in   3           ahb_burst_t; informational only, not decoded
//  ahb_hprot_i      in   4           ignored
//  ahb_hwrite_i     in   1           1 = write
//  ahb_hready_i     in   1           bus-level HREADY
//  ahb_hwdata_i     in   32          write data, valid during the data phase
//  ahb_hreadyout_o  out  1           slave ready
//  ahb_hresp_o      out  2           ahb_resp_t; only OKAY and ERROR are ever driven
//  ahb_hrdata_o     out  32          read data
//  mem_addr_o       out  $clog2(MEM_DEPTH)  SRAM word address
//  mem_re_o         out  1           SRAM read enable
//  mem_we_o         out  1           SRAM write enable
//  mem_wstrb_o      out  4           byte write strobes
//  mem_wdata_o      out  32          SRAM write data; always equals ahb_hwdata_i
//  mem_rdata_i      in   32          SRAM read data, valid 1 cycle after mem_re_o
// BEHAVIOUR
//  Address phase is accepted when hsel & hready_i & htrans is NONSEQ or SEQ.
//  - IDLE, BUSY or unselected: no SRAM access; OKAY with zero wait states.
//  Error check runs at accept. A transfer is an error if any of these hold:
//  - hsize > AHB_SIZE_32_BIT
//  - address is misaligned to hsize
//  - haddr[ADDR_WIDTH-1:2] >= MEM_DEPTH
//  An error transfer makes no SRAM access.
//  Data-phase FSM states: DP_NONE, DP_READ, DP_WRITE, DP_WSTALL, DP_ERR1, DP_ERR2.
//  - DP_NONE: hreadyout=1, hresp=OKAY, hrdata=0.
//  - Read accept: mem_re_o=1 and mem_addr_o = haddr word, driven combinationally in the
//    address cycle. Next state DP_READ.
//  - DP_READ: hrdata=mem_rdata_i, hreadyout=1. Zero wait states, including back-to-back
//    SEQ reads.
//  - Write accept: address word and strobes are registered; next state DP_WRITE.
//  - DP_WRITE: mem_we_o=1 with the registered address and strobes.
//    - If a read is presented at the same time, the port conflicts: hreadyout=0, the
//      read is not accepted, and the state goes to DP_WSTALL.
//    - Otherwise hreadyout=1 and a following write or idle is accepted normally
//      (zero wait states).
//  - DP_WSTALL: mem_we_o=0, hreadyout=1. The held read is accepted now (mem_re_o=1).
//    This gives exactly 1 wait state for write-then-read.
//  - Error: DP_ERR1 (hreadyout=0, hresp=ERROR), then DP_ERR2 (hreadyout=1, hresp=ERROR).
//    - No transfer is accepted during DP_ERR1.
//    - A transfer presented in DP_ERR2 is accepted normally.
//  Strobes (little-endian, offset = haddr[1:0]):
//  - 8-bit: 4'b0001 << offset
//  - 16-bit: 4'b0011 << offset, with offset in {0,2}
//  - 32-bit: 4'b1111, with offset 0
//  hrdata is the full word; the master selects byte lanes.
//  Reset, taken on any cycle including mid-burst, DP_WSTALL or DP_ERR1:
//  - state DP_NONE, hreadyout=1, hresp=OKAY, hrdata=0
//  - mem_re=0, mem_we=0, mem_wstrb=0, mem_addr=0
//  - a pending write is dropped and not committed
//  mem_re_o and mem_we_o are never both 1 in the same cycle.
// STRUCTURE
//  ahb_trans_t, ahb_size_t, ahb_burst_t and ahb_resp_t come from the shared ahb_enum
//  package.
//  The data-phase state enum is local to this module.
//  One sub-module, ahb_strb_gen (combinational):
//  - inputs: hsize, haddr[1:0]
//  - outputs: wstrb[3:0], misalign
//  - reused by future AHB slaves
// TESTING
//  1 Single write then read, idle between:
//    - stimulus: NONSEQ write 32-bit 0x10 = 0xDEADBEEF, IDLE, NONSEQ read 0x10
//    - response: mem_we with addr 4 and strb 1111; hrdata 0xDEADBEEF; no wait states
//  2 Write immediately followed by read:
//    - stimulus: write 0x20, then read 0x20 in the next cycle
//    - response: one cycle hreadyout=0 (DP_WSTALL path); read returns the written data
//  3 INCR4 byte writes:
//    - stimulus: SEQ bytes to 0x40..0x43 = 11,22,33,44
//    - response: strb 0001, 0010, 0100, 1000 in turn; a 32-bit read returns 0x44332211
//  4 Errors:
//    - 16-bit at 0x01 -> DP_ERR1 then DP_ERR2, hresp=ERROR for both cycles, no mem_we
//    - 64-bit size -> same 2-cycle ERROR, no access
//    - address MEM_DEPTH*4 -> same 2-cycle ERROR, no access
//  5 BUSY mid-burst:
//    - stimulus: INCR read with BUSY inserted
//    - response: BUSY gives OKAY with zero wait states and no mem_re; the burst resumes
//      with correct data
//  6 Reset in DP_ERR1 and in DP_WSTALL:
//    - all outputs at reset values in the next cycle; the stalled write is not repeated

Source files
------------

// File: rtl/ahb_enum_pkg.sv
// Shared AHB-Lite encodings used by every slave on the interconnect.
package ahb_enum_pkg;

    typedef enum logic [1:0] {
        AHB_TRANS_IDLE   = 2'b00,
        AHB_TRANS_BUSY   = 2'b01,
        AHB_TRANS_NONSEQ = 2'b10,
        AHB_TRANS_SEQ    = 2'b11
    } ahb_trans_t;

    typedef enum logic [2:0] {
        AHB_SIZE_8_BIT    = 3'd0,
        AHB_SIZE_16_BIT   = 3'd1,
        AHB_SIZE_32_BIT   = 3'd2,
        AHB_SIZE_64_BIT   = 3'd3,
        AHB_SIZE_128_BIT  = 3'd4,
        AHB_SIZE_256_BIT  = 3'd5,
        AHB_SIZE_512_BIT  = 3'd6,
        AHB_SIZE_1024_BIT = 3'd7
    } ahb_size_t;

    typedef enum logic [2:0] {
        AHB_BURST_SINGLE = 3'd0,
        AHB_BURST_INCR   = 3'd1,
        AHB_BURST_WRAP4  = 3'd2,
        AHB_BURST_INCR4  = 3'd3,
        AHB_BURST_WRAP8  = 3'd4,
        AHB_BURST_INCR8  = 3'd5,
        AHB_BURST_WRAP16 = 3'd6,
        AHB_BURST_INCR16 = 3'd7
    } ahb_burst_t;

    typedef enum logic [1:0] {
        AHB_RESP_OKAY  = 2'b00,
        AHB_RESP_ERROR = 2'b01,
        AHB_RESP_RETRY = 2'b10,
        AHB_RESP_SPLIT = 2'b11
    } ahb_resp_t;

    function automatic logic ahb_trans_active(input ahb_trans_t t);
        return (t == AHB_TRANS_NONSEQ) || (t == AHB_TRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_sram_slave_strb_gen.sv
// Little-endian byte-lane strobe and alignment decode for 32-bit AHB slaves.
module ahb_strb_gen
    import ahb_enum_pkg::*;
(
    input  ahb_size_t   hsize_i,
    input  logic [1:0]  addr_lo_i,
    output logic [3:0]  wstrb_o,
    output logic        misalign_o
);

    // Sizes wider than the bus yield no strobes; the caller flags them separately.
    always_comb begin
        wstrb_o    = 4'b0000;
        misalign_o = 1'b0;
        case (hsize_i)
            AHB_SIZE_8_BIT: begin
                wstrb_o = 4'b0001 << addr_lo_i;
            end
            AHB_SIZE_16_BIT: begin
                wstrb_o    = 4'b0011 << addr_lo_i;
                misalign_o = addr_lo_i[0];
            end
            AHB_SIZE_32_BIT: begin
                wstrb_o    = 4'b1111;
                misalign_o = |addr_lo_i;
            end
            default: begin
                wstrb_o    = 4'b0000;
                misalign_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave bridging bus transfers onto a single-port SRAM with 1-cycle read latency.
module ahb_sram_slave
    import ahb_enum_pkg::*;
#(
    parameter  int ADDR_WIDTH = 32,
    parameter  int MEM_DEPTH  = 1024,
    localparam int MEM_AW     = $clog2(MEM_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  ahb_hsel_i,
    input  logic [ADDR_WIDTH-1:0] ahb_haddr_i,
    input  logic [1:0]            ahb_htrans_i,
    input  logic [2:0]            ahb_hsize_i,
    input  logic [2:0]            ahb_hburst_i,
    input  logic [3:0]            ahb_hprot_i,
    input  logic                  ahb_hwrite_i,
    input  logic                  ahb_hready_i,
    input  logic [31:0]           ahb_hwdata_i,
    output logic                  ahb_hreadyout_o,
    output logic [1:0]            ahb_hresp_o,
    output logic [31:0]           ahb_hrdata_o,
    output logic [MEM_AW-1:0]     mem_addr_o,
    output logic                  mem_re_o,
    output logic                  mem_we_o,
    output logic [3:0]            mem_wstrb_o,
    output logic [31:0]           mem_wdata_o,
    input  logic [31:0]           mem_rdata_i
);

    typedef enum logic [2:0] {
        DP_NONE   = 3'd0,
        DP_READ   = 3'd1,
        DP_WRITE  = 3'd2,
        DP_WSTALL = 3'd3,
        DP_ERR1   = 3'd4,
        DP_ERR2   = 3'd5
    } dp_state_t;

    dp_state_t          state_q, state_d;
    logic [MEM_AW-1:0]  waddr_q, waddr_d;
    logic [3:0]         wstrb_q, wstrb_d;

    ahb_trans_t         htrans;
    ahb_size_t          hsize;
    logic [3:0]         strb;
    logic               misalign;
    logic               req;
    logic               conflict;
    logic               accept;
    logic               out_of_range;
    logic               xfer_err;
    logic               rd_go;
    logic               wr_commit;
    logic [MEM_AW-1:0]  haddr_word;
    logic               unused_ok;

    assign htrans     = ahb_trans_t'(ahb_htrans_i);
    assign hsize      = ahb_size_t'(ahb_hsize_i);
    assign haddr_word = ahb_haddr_i[MEM_AW+1:2];
    assign unused_ok  = ^{ahb_hburst_i, ahb_hprot_i};

    ahb_strb_gen u_strb_gen (
        .hsize_i    (hsize),
        .addr_lo_i  (ahb_haddr_i[1:0]),
        .wstrb_o    (strb),
        .misalign_o (misalign)
    );

    // The conflict term deliberately ignores hready_i: this slave is the one driving it low.
    assign req          = ahb_hsel_i && ahb_trans_active(htrans);
    assign conflict     = (state_q == DP_WRITE) && req && !ahb_hwrite_i;
    assign accept       = rst_n_i && req && ahb_hready_i && (state_q != DP_ERR1) && !conflict;
    assign out_of_range = ahb_haddr_i[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(MEM_DEPTH);
    assign xfer_err     = (hsize > AHB_SIZE_32_BIT) || misalign || out_of_range;
    assign rd_go        = accept && !xfer_err && !ahb_hwrite_i;
    assign wr_commit    = rst_n_i && (state_q == DP_WRITE);

    always_comb begin
        state_d = DP_NONE;
        waddr_d = waddr_q;
        wstrb_d = wstrb_q;
        if (state_q == DP_ERR1) begin
            state_d = DP_ERR2;
        end else if (conflict) begin
            state_d = DP_WSTALL;
        end else if (accept) begin
            if (xfer_err) begin
                state_d = DP_ERR1;
            end else if (ahb_hwrite_i) begin
                state_d = DP_WRITE;
                waddr_d = haddr_word;
                wstrb_d = strb;
            end else begin
                state_d = DP_READ;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= DP_NONE;
            waddr_q <= '0;
            wstrb_q <= '0;
        end else begin
            state_q <= state_d;
            waddr_q <= waddr_d;
            wstrb_q <= wstrb_d;
        end
    end

    // A read is never granted while a write commits, so re and we stay exclusive.
    assign mem_re_o    = rd_go;
    assign mem_we_o    = wr_commit;
    assign mem_addr_o  = wr_commit ? waddr_q : (rd_go ? haddr_word : '0);
    assign mem_wstrb_o = wr_commit ? wstrb_q : 4'b0000;
    assign mem_wdata_o = ahb_hwdata_i;

    assign ahb_hreadyout_o = !((state_q == DP_ERR1) || conflict);
    assign ahb_hresp_o     = ((state_q == DP_ERR1) || (state_q == DP_ERR2)) ? AHB_RESP_ERROR
                                                                             : AHB_RESP_OKAY;
    assign ahb_hrdata_o    = (state_q == DP_READ) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave with a behavioural single-port SRAM behind it.
module tb_ahb_sram_slave;

    localparam logic [1:0] T_IDLE = 2'd0;
    localparam logic [1:0] T_BUSY = 2'd1;
    localparam logic [1:0] T_NSEQ = 2'd2;
    localparam logic [1:0] T_SEQ  = 2'd3;
    localparam logic [2:0] S8  = 3'd0;
    localparam logic [2:0] S16 = 3'd1;
    localparam logic [2:0] S32 = 3'd2;
    localparam logic [2:0] S64 = 3'd3;

    logic        clk;
    logic        rst_n;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic        hwrite;
    logic        hready;
    logic [31:0] hwdata;
    logic        hreadyout;
    logic [1:0]  hresp;
    logic [31:0] hrdata;
    logic [9:0]  mem_addr;
    logic        mem_re;
    logic        mem_we;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    logic [31:0] sram [0:1023];
    int          n_tests;
    int          n_fail;

    assign hready = hreadyout;

    ahb_sram_slave #(.ADDR_WIDTH(32), .MEM_DEPTH(1024)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .ahb_hsel_i      (hsel),
        .ahb_haddr_i     (haddr),
        .ahb_htrans_i    (htrans),
        .ahb_hsize_i     (hsize),
        .ahb_hburst_i    (3'd1),
        .ahb_hprot_i     (4'd3),
        .ahb_hwrite_i    (hwrite),
        .ahb_hready_i    (hready),
        .ahb_hwdata_i    (hwdata),
        .ahb_hreadyout_o (hreadyout),
        .ahb_hresp_o     (hresp),
        .ahb_hrdata_o    (hrdata),
        .mem_addr_o      (mem_addr),
        .mem_re_o        (mem_re),
        .mem_we_o        (mem_we),
        .mem_wstrb_o     (mem_wstrb),
        .mem_wdata_o     (mem_wdata),
        .mem_rdata_i     (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wstrb[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
        if (mem_re) mem_rdata <= sram[mem_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic s, input logic [1:0] t, input logic [31:0] a,
                       input logic [2:0] z, input logic w, input logic [31:0] d);
        hsel = s; htrans = t; haddr = a; hsize = z; hwrite = w; hwdata = d;
        @(negedge clk);
    endtask

    task automatic idle(input logic [31:0] d);
        drv(1'b0, T_IDLE, 32'h0, S32, 1'b0, d);
    endtask

    task automatic adv;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        mem_rdata = 32'h0;
        for (int i = 0; i < 1024; i++) sram[i] = 32'h0;
        rst_n = 1'b0;
        hsel = 1'b0; htrans = T_IDLE; haddr = 32'h0; hsize = S32; hwrite = 1'b0; hwdata = 32'h0;
        adv; adv;

        // Reset state
        idle(32'h0);
        chk("rst_hreadyout", 32'(hreadyout), 32'd1);
        chk("rst_hresp",     32'(hresp),     32'd0);
        chk("rst_hrdata",    hrdata,         32'h0);
        chk("rst_mem_re",    32'(mem_re),    32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_wstrb",     32'(mem_wstrb), 32'd0);
        chk("rst_addr",      32'(mem_addr),  32'd0);
        adv;
        rst_n = 1'b1;
        adv;

        // 1: write, idle, read
        drv(1'b1, T_NSEQ, 32'h10, S32, 1'b1, 32'h0);
        chk("t1_aph_we", 32'(mem_we), 32'd0);
        chk("t1_aph_re", 32'(mem_re), 32'd0);
        adv;
        idle(32'hDEADBEEF);
        chk("t1_we",    32'(mem_we),    32'd1);
        chk("t1_addr",  32'(mem_addr),  32'd4);
        chk("t1_strb",  32'(mem_wstrb), 32'hF);
        chk("t1_wdata", mem_wdata,      32'hDEADBEEF);
        chk("t1_wrdy",  32'(hreadyout), 32'd1);
        adv;
        drv(1'b1, T_NSEQ, 32'h10, S32, 1'b0, 32'h0);
        chk("t1_re",    32'(mem_re),    32'd1);
        chk("t1_raddr", 32'(mem_addr),  32'd4);
        adv;
        idle(32'h0);
        chk("t1_rdata", hrdata,         32'hDEADBEEF);
        chk("t1_rrdy",  32'(hreadyout), 32'd1);
        adv;

        // 2: write immediately followed by read
        drv(1'b1, T_NSEQ, 32'h20, S32, 1'b1, 32'h0);
        adv;
        drv(1'b1, T_NSEQ, 32'h20, S32, 1'b0, 32'h12345678);
        chk("t2_stall_rdy", 32'(hreadyout), 32'd0);
        chk("t2_stall_we",  32'(mem_we),    32'd1);
        chk("t2_stall_re",  32'(mem_re),    32'd0);
        chk("t2_waddr",     32'(mem_addr),  32'd8);
        adv;
        drv(1'b1, T_NSEQ, 32'h20, S32, 1'b0, 32'h12345678);
        chk("t2_ws_we",  32'(mem_we),    32'd0);
        chk("t2_ws_re",  32'(mem_re),    32'd1);
        chk("t2_ws_rdy", 32'(hreadyout), 32'd1);
        chk("t2_raddr",  32'(mem_addr),  32'd8);
        adv;
        idle(32'h0);
        chk("t2_rdata", hrdata, 32'h12345678);
        adv;

        // 3: INCR4 byte writes, then word read
        drv(1'b1, T_NSEQ, 32'h40, S8, 1'b1, 32'h0);
        adv;
        drv(1'b1, T_SEQ, 32'h41, S8, 1'b1, 32'h11111111);
        chk("t3_strb0", 32'(mem_wstrb), 32'h1);
        chk("t3_addr0", 32'(mem_addr),  32'h10);
        adv;
        drv(1'b1, T_SEQ, 32'h42, S8, 1'b1, 32'h22222222);
        chk("t3_strb1", 32'(mem_wstrb), 32'h2);
        adv;
        drv(1'b1, T_SEQ, 32'h43, S8, 1'b1, 32'h33333333);
        chk("t3_strb2", 32'(mem_wstrb), 32'h4);
        adv;
        idle(32'h44444444);
        chk("t3_strb3", 32'(mem_wstrb), 32'h8);
        adv;
        drv(1'b1, T_NSEQ, 32'h40, S32, 1'b0, 32'h0);
        adv;
        idle(32'h0);
        chk("t3_rdata", hrdata, 32'h44332211);
        adv;

        // 4a: misaligned halfword write
        drv(1'b1, T_NSEQ, 32'h01, S16, 1'b1, 32'h0);
        chk("t4a_aph_re", 32'(mem_re), 32'd0);
        adv;
        idle(32'hFFFFFFFF);
        chk("t4a_e1_rdy",  32'(hreadyout), 32'd0);
        chk("t4a_e1_resp", 32'(hresp),     32'd1);
        chk("t4a_e1_we",   32'(mem_we),    32'd0);
        adv;
        idle(32'h0);
        chk("t4a_e2_rdy",  32'(hreadyout), 32'd1);
        chk("t4a_e2_resp", 32'(hresp),     32'd1);
        chk("t4a_e2_we",   32'(mem_we),    32'd0);
        adv;
        idle(32'h0);
        chk("t4a_after_resp", 32'(hresp), 32'd0);
        adv;

        // 4b: 64-bit size
        drv(1'b1, T_NSEQ, 32'h0, S64, 1'b0, 32'h0);
        chk("t4b_aph_re", 32'(mem_re), 32'd0);
        adv;
        idle(32'h0);
        chk("t4b_e1_rdy",  32'(hreadyout), 32'd0);
        chk("t4b_e1_resp", 32'(hresp),     32'd1);
        adv;
        idle(32'h0);
        chk("t4b_e2_rdy",  32'(hreadyout), 32'd1);
        chk("t4b_e2_resp", 32'(hresp),     32'd1);
        adv;

        // 4c: first address past the end; a read presented in ERR2 is accepted
        drv(1'b1, T_NSEQ, 32'h1000, S32, 1'b0, 32'h0);
        chk("t4c_aph_re", 32'(mem_re), 32'd0);
        adv;
        idle(32'h0);
        chk("t4c_e1_rdy",  32'(hreadyout), 32'd0);
        chk("t4c_e1_resp", 32'(hresp),     32'd1);
        chk("t4c_e1_re",   32'(mem_re),    32'd0);
        adv;
        drv(1'b1, T_NSEQ, 32'h10, S32, 1'b0, 32'h0);
        chk("t4c_e2_resp", 32'(hresp),     32'd1);
        chk("t4c_e2_rdy",  32'(hreadyout), 32'd1);
        chk("t4c_e2_re",   32'(mem_re),    32'd1);
        adv;
        idle(32'h0);
        chk("t4c_rdata", hrdata,     32'hDEADBEEF);
        chk("t4c_resp",  32'(hresp), 32'd0);
        adv;

        // 5: INCR read burst with BUSY
        drv(1'b1, T_NSEQ, 32'h38, S32, 1'b1, 32'h0);
        adv;
        drv(1'b1, T_SEQ, 32'h3C, S32, 1'b1, 32'hA1B2C3D4);
        adv;
        idle(32'h5566AA77);
        adv;
        drv(1'b1, T_NSEQ, 32'h38, S32, 1'b0, 32'h0);
        chk("t5_re0", 32'(mem_re), 32'd1);
        adv;
        drv(1'b1, T_SEQ, 32'h3C, S32, 1'b0, 32'h0);
        chk("t5_d0",   hrdata,         32'hA1B2C3D4);
        chk("t5_rdy0", 32'(hreadyout), 32'd1);
        chk("t5_re1",  32'(mem_re),    32'd1);
        chk("t5_a1",   32'(mem_addr),  32'hF);
        adv;
        drv(1'b1, T_BUSY, 32'h40, S32, 1'b0, 32'h0);
        chk("t5_d1",       hrdata,         32'h5566AA77);
        chk("t5_busy_re",  32'(mem_re),    32'd0);
        chk("t5_busy_rdy", 32'(hreadyout), 32'd1);
        adv;
        drv(1'b1, T_SEQ, 32'h40, S32, 1'b0, 32'h0);
        chk("t5_busy_resp",  32'(hresp),    32'd0);
        chk("t5_busy_rdata", hrdata,        32'h0);
        chk("t5_re2",        32'(mem_re),   32'd1);
        chk("t5_a2",         32'(mem_addr), 32'h10);
        adv;
        idle(32'h0);
        chk("t5_d2", hrdata, 32'h44332211);
        adv;

        // 6a: reset in DP_ERR1
        drv(1'b1, T_NSEQ, 32'h0, S64, 1'b0, 32'h0);
        adv;
        rst_n = 1'b0;
        idle(32'h0);
        adv;
        rst_n = 1'b1;
        idle(32'h0);
        chk("t6a_rdy",  32'(hreadyout), 32'd1);
        chk("t6a_resp", 32'(hresp),     32'd0);
        adv;

        // 6b: reset in DP_WSTALL
        drv(1'b1, T_NSEQ, 32'h50, S32, 1'b1, 32'h0);
        adv;
        drv(1'b1, T_NSEQ, 32'h50, S32, 1'b0, 32'h77777777);
        chk("t6b_stall", 32'(hreadyout), 32'd0);
        adv;
        rst_n = 1'b0;
        drv(1'b1, T_NSEQ, 32'h50, S32, 1'b0, 32'h77777777);
        chk("t6b_rst_re", 32'(mem_re), 32'd0);
        adv;
        rst_n = 1'b1;
        idle(32'h0);
        chk("t6b_we",     32'(mem_we),    32'd0);
        chk("t6b_re",     32'(mem_re),    32'd0);
        chk("t6b_rdy",    32'(hreadyout), 32'd1);
        chk("t6b_hrdata", hrdata,         32'h0);
        chk("t6b_strb",   32'(mem_wstrb), 32'd0);
        chk("t6b_addr",   32'(mem_addr),  32'd0);
        adv;

        // 6c: reset during DP_WRITE drops the pending write
        drv(1'b1, T_NSEQ, 32'h60, S32, 1'b1, 32'h0);
        adv;
        rst_n = 1'b0;
        idle(32'hBADBAD00);
        chk("t6c_drop_we", 32'(mem_we), 32'd0);
        adv;
        rst_n = 1'b1;
        drv(1'b1, T_NSEQ, 32'h60, S32, 1'b0, 32'h0);
        adv;
        idle(32'h0);
        chk("t6c_rdata", hrdata, 32'h0);
        adv;
        drv(1'b1, T_NSEQ, 32'h50, S32, 1'b0, 32'h0);
        adv;
        idle(32'h0);
        chk("t6b_rdata", hrdata, 32'h77777777);
        adv;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
